ofm_pack_buf: RTL and testbench
===============================

# ofm_pack_buf

Parametrised output-feature-map packing buffer. It accepts a stream of `ELEM_W`-bit OFM elements from the post-processing stage and packs `PACK_N` elements into one `WORD_W`-bit word. Completed words are queued in a `DEPTH`-entry FIFO and drained over a valid/ready port toward the OFM write-back path. It adds backpressure on both sides, end-of-tile flush of partial words, a selectable lane order and a synchronous abort.

## Interface
Parameters:
- `ELEM_W`, default 8, element width.
- `WORD_W`, default 32, packed word width. Constraint: `PACK_N*ELEM_W <= WORD_W`.
- `PACK_N`, default 3, elements per word; ≥1.
- `DEPTH`, default 4, output FIFO entries; power of two, ≥2.
- `MSB_FIRST`, default 1:
  - 1: first element goes to the highest used lane.
  - 0: first element goes to lane 0 (LSBs).

Ports (reset `rst_n`, asynchronous, active-low; clock `clk`):
- `clk` in 1: clock.
- `rst_n` in 1: async active-low reset.
- `clear` in 1: synchronous abort; drops the partial word and empties the FIFO.
- `in_valid` in 1: element valid.
- `in_ready` out 1: element accepted when `in_valid && in_ready`.
- `in_data` in `ELEM_W`: element.
- `in_last` in 1: last element of tile; forces word commit.
- `out_valid` out 1: FIFO head valid.
- `out_ready` in 1: consumer accepts head.
- `out_data` out `WORD_W`: packed word.
- `out_last` out 1: word closes a tile.
- `out_count` out `$clog2(PACK_N+1)`: elements present in word, 1..`PACK_N`.
- `fill_level` out `$clog2(DEPTH+1)`: FIFO occupancy.

## Operation
- Assembly register `asm` (`WORD_W` bits) and element counter `ecnt` (0..`PACK_N-1`).
- Lane placement for accepted element k = `ecnt`:
  - `MSB_FIRST=1`: written to bits `[(PACK_N-k)*ELEM_W-1 -: ELEM_W]`. With the defaults, the first element lands at `[23:16]`.
  - `MSB_FIRST=0`: written to `[k*ELEM_W +: ELEM_W]`.
  - Bits above `PACK_N*ELEM_W` are always 0.
- Commit occurs on an accepted beat with `ecnt==PACK_N-1` or `in_last==1`:
  - Push `{word, last=in_last, count=ecnt+1}` into the FIFO.
  - The pushed word is `asm` with the current element merged in.
  - Clear `asm` to 0 and set `ecnt` to 0.
  - Unfilled lanes of a partial word are 0.
- Otherwise, an accepted beat writes its lane and increments `ecnt`.
- `in_ready = !full && !clear`. There is no same-cycle pop/push bypass when full.
- `out_valid = !empty && !clear`. `out_data`, `out_last` and `out_count` show the FIFO head and read 0 when empty.
- Pop occurs on `out_valid && out_ready`. Simultaneous push and pop leaves `fill_level` unchanged.
- `in_last` on a beat with `ecnt==PACK_N-1` gives a full word with `out_last=1`. There is never an empty word.
- FIFO pointers are `$clog2(DEPTH)` bits and wrap; full/empty are tracked by the occupancy counter.
- `clear` has priority over every other event:
  - In the clear cycle, no accept and no pop.
  - Next cycle: `asm=0`, `ecnt=0`, FIFO empty.
- Reset mid-operation: all state is discarded immediately; partial data is lost.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_last=0`, `out_count=0`, `fill_level=0`, internal `ecnt=0`, `asm=0`.
- `in_ready` is combinational from `full`/`clear`, so it reads 1 during reset. Beats presented during reset are ignored.
- Latency: a committed word appears at the FIFO head (`out_valid=1`) on the cycle after the committing beat, when the FIFO was empty.
- Throughput: one element per cycle sustained while `out_ready` is held high. Drain rate is then 1 word per `PACK_N` cycles.
- `fill_level` updates one cycle after each push/pop.
- Backpressure: with `out_ready=0`, `in_ready` drops the cycle after the `DEPTH`-th word is pushed. It returns high the cycle after the first pop.
- Handshake rule: `in_data`/`in_last` are sampled only on accept. Outputs hold stable while `out_valid && !out_ready`.

## Structure
- Package `ofm_pkg` holds:
  - Function `lane_lsb(k, PACK_N, ELEM_W, MSB_FIRST)` returning the lane base bit.
  - Typedef for the FIFO entry struct `{data, last, count}`, with widths derived from `WORD_W` and `PACK_N`.
- Sub-module `ofm_word_fifo`: synchronous FIFO, `DEPTH` entries, width `WORD_W+1+$clog2(PACK_N+1)`.
  - Ports: push/pop/clear, full/empty/level.
- Top-level `ofm_pack_buf` contains the assembler, the commit logic and the handshake gating.

## Test plan
- Default params, inputs 0x11,0x22,0x33 back-to-back with `out_ready=1` -> one word 0x00112233, `out_count=3`, `out_last=0`, `out_valid` high one cycle after 0x33 is accepted.
- `MSB_FIRST=0`, inputs 0xAA,0xBB,0xCC -> word 0x00CCBBAA.
- Defaults, inputs 0x44,0x55 with `in_last` on 0x55 -> word 0x00445500, `out_count=2`, `out_last=1`. The next element starts at lane 0 of a fresh word.
- `out_ready=0`, stream 12 elements -> 4 words queued, `fill_level=4`, `in_ready=0` after the 4th commit. Raise `out_ready` -> words drain in order and `in_ready` returns high one cycle after the first pop.
- Assert `clear` with 1 partial element and 2 queued words, `in_valid=1` in the same cycle -> that beat is not accepted. Next cycle: `out_valid=0`, `fill_level=0`. The next 3 elements form a clean word.
- Assert `rst_n` low with 2 words queued and a partial word -> all outputs go to 0 immediately. After release, the first 3 elements produce a correct word.

Source files
------------

// File: rtl/ofm_pkg.sv
// Shared helpers and entry layout for the OFM packing buffer.
package ofm_pkg;

    localparam int unsigned DEF_WORD_W = 32;
    localparam int unsigned DEF_PACK_N = 3;
    localparam int unsigned DEF_CNT_W  = $clog2(DEF_PACK_N + 1);

    // FIFO entry layout for the default build; the top re-derives it from its own parameters.
    typedef struct packed {
        logic [DEF_WORD_W-1:0] data;
        logic                  last;
        logic [DEF_CNT_W-1:0]  count;
    } ofm_entry_t;

    // Base bit of the lane that element k of a word occupies.
    function automatic int unsigned lane_lsb(
        input int unsigned k,
        input int unsigned pack_n,
        input int unsigned elem_w,
        input bit          msb_first
    );
        return msb_first ? (pack_n - 1 - k) * elem_w : k * elem_w;
    endfunction

endpackage

// File: rtl/ofm_word_fifo.sv
// Synchronous word FIFO; occupancy counter decides full/empty, head reads 0 when empty.
module ofm_word_fifo #(
    parameter int unsigned DW    = 35,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         push,
    input  logic                         pop,
    input  logic [DW-1:0]                din,
    output logic [DW-1:0]                dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    logic [DW-1:0]    r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [LVL_W-1:0] r_lvl;
    logic             w_push;
    logic             w_pop;

    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    assign full  = (r_lvl == LVL_W'(DEPTH));
    assign empty = (r_lvl == '0);
    assign level = r_lvl;
    assign dout  = empty ? '0 : r_mem[r_rd];

    // Storage carries no reset; stale contents are never visible while empty.
    always_ff @(posedge clk) begin
        if (w_push && !clear) begin
            r_mem[r_wr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_lvl <= '0;
        end else if (clear) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_lvl <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop)  r_rd <= r_rd + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_lvl <= r_lvl + LVL_W'(1);
                2'b01:   r_lvl <= r_lvl - LVL_W'(1);
                default: r_lvl <= r_lvl;
            endcase
        end
    end

endmodule

// File: rtl/ofm_pack_buf.sv
// OFM packing buffer: packs PACK_N elements per word, queues words, drains via valid/ready.
module ofm_pack_buf
    import ofm_pkg::*;
#(
    parameter int unsigned ELEM_W    = 8,
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned PACK_N    = 3,
    parameter int unsigned DEPTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [ELEM_W-1:0]             in_data,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WORD_W-1:0]             out_data,
    output logic                          out_last,
    output logic [$clog2(PACK_N+1)-1:0]   out_count,
    output logic [$clog2(DEPTH+1)-1:0]    fill_level
);

    localparam int unsigned CNT_W  = $clog2(PACK_N + 1);
    localparam int unsigned LVL_W  = $clog2(DEPTH + 1);
    localparam int unsigned ECNT_W = (PACK_N > 1) ? $clog2(PACK_N) : 1;
    localparam int unsigned ENT_W  = WORD_W + 1 + CNT_W;

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic              last;
        logic [CNT_W-1:0]  count;
    } entry_t;

    logic [WORD_W-1:0] r_asm;
    logic [ECNT_W-1:0] r_ecnt;

    logic              w_accept;
    logic              w_commit;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [31:0]       w_lsb;
    logic [WORD_W-1:0] w_merged;
    entry_t            w_push_ent;
    entry_t            w_head_ent;
    logic [ENT_W-1:0]  w_head_bits;
    logic [LVL_W-1:0]  w_level;

    assign in_ready  = !w_full && !clear;
    assign out_valid = !w_empty && !clear;
    assign w_accept  = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign w_commit  = w_accept && ((r_ecnt == ECNT_W'(PACK_N - 1)) || in_last);

    // Lanes start at zero, so OR-ing the shifted element places it in its lane.
    assign w_lsb    = lane_lsb(32'(r_ecnt), PACK_N, ELEM_W, MSB_FIRST);
    assign w_merged = r_asm | (WORD_W'(in_data) << w_lsb);

    always_comb begin
        w_push_ent       = '0;
        w_push_ent.data  = w_merged;
        w_push_ent.last  = in_last;
        w_push_ent.count = CNT_W'(r_ecnt) + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_asm  <= '0;
            r_ecnt <= '0;
        end else if (clear) begin
            r_asm  <= '0;
            r_ecnt <= '0;
        end else if (w_accept) begin
            if (w_commit) begin
                r_asm  <= '0;
                r_ecnt <= '0;
            end else begin
                r_asm  <= w_merged;
                r_ecnt <= r_ecnt + ECNT_W'(1);
            end
        end
    end

    ofm_word_fifo #(
        .DW    (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .push  (w_commit),
        .pop   (w_pop),
        .din   (w_push_ent),
        .dout  (w_head_bits),
        .full  (w_full),
        .empty (w_empty),
        .level (w_level)
    );

    assign w_head_ent = w_head_bits;
    assign out_data   = w_head_ent.data;
    assign out_last   = w_head_ent.last;
    assign out_count  = w_head_ent.count;
    assign fill_level = w_level;

endmodule

// File: tb/tb_ofm_pack_buf.sv
// Bench for ofm_pack_buf: MSB-first and LSB-first instances against a queue-based model.
module tb_ofm_pack_buf;

    localparam int unsigned ELEM_W = 8;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned PACK_N = 3;
    localparam int unsigned DEPTH  = 4;

    logic              clk;
    logic              rst_n;
    logic              clear;
    logic              in_valid;
    logic [ELEM_W-1:0] in_data;
    logic              in_last;
    logic              out_ready;

    logic              in_ready_m, out_valid_m, out_last_m;
    logic [WORD_W-1:0] out_data_m;
    logic [1:0]        out_count_m;
    logic [2:0]        fill_m;
    logic              in_ready_l, out_valid_l, out_last_l;
    logic [WORD_W-1:0] out_data_l;
    logic [1:0]        out_count_l;
    logic [2:0]        fill_l;

    ofm_pack_buf u_msb (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready_m), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid_m), .out_ready(out_ready), .out_data(out_data_m),
        .out_last(out_last_m), .out_count(out_count_m), .fill_level(fill_m)
    );

    ofm_pack_buf #(.MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready_l), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid_l), .out_ready(out_ready), .out_data(out_data_l),
        .out_last(out_last_l), .out_count(out_count_l), .fill_level(fill_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] dm;
        logic [31:0] dl;
        logic        last;
        int          cnt;
    } exp_t;

    exp_t       q[$];
    logic [7:0] part[$];
    int         n_cmp = 0;
    int         n_mis = 0;
    bit         last_acc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_mis++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Compare every output against the model, then advance one clock.
    task automatic tick();
        bit   m_rdy, m_val, m_pop;
        exp_t h, e;
        #1;
        m_rdy = (q.size() < DEPTH) && !clear;
        m_val = (q.size() > 0) && !clear;
        if (q.size() > 0) h = q[0];
        else h = '{dm: 32'h0, dl: 32'h0, last: 1'b0, cnt: 0};
        chk("in_ready_m",  64'(in_ready_m),  64'(m_rdy));
        chk("in_ready_l",  64'(in_ready_l),  64'(m_rdy));
        chk("out_valid_m", 64'(out_valid_m), 64'(m_val));
        chk("out_valid_l", 64'(out_valid_l), 64'(m_val));
        chk("out_data_m",  64'(out_data_m),  64'(h.dm));
        chk("out_data_l",  64'(out_data_l),  64'(h.dl));
        chk("out_last_m",  64'(out_last_m),  64'(h.last));
        chk("out_last_l",  64'(out_last_l),  64'(h.last));
        chk("out_count_m", 64'(out_count_m), 64'(h.cnt));
        chk("out_count_l", 64'(out_count_l), 64'(h.cnt));
        chk("fill_m",      64'(fill_m),      64'(q.size()));
        chk("fill_l",      64'(fill_l),      64'(q.size()));
        last_acc = in_valid && m_rdy;
        m_pop    = out_ready && m_val;
        @(posedge clk);
        if (clear) begin
            q.delete();
            part.delete();
        end else begin
            if (m_pop) void'(q.pop_front());
            if (last_acc) begin
                part.push_back(in_data);
                if (part.size() == PACK_N || in_last) begin
                    e.dm = 32'h0;
                    e.dl = 32'h0;
                    for (int i = 0; i < part.size(); i++) begin
                        e.dm = e.dm | (32'(part[i]) << ((PACK_N - 1 - i) * ELEM_W));
                        e.dl = e.dl | (32'(part[i]) << (i * ELEM_W));
                    end
                    e.last = in_last;
                    e.cnt  = part.size();
                    q.push_back(e);
                    part.delete();
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input bit l);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        do begin
            tick();
            n++;
        end while (!last_acc && n < 64);
        if (!last_acc) chk("send_timeout", 64'(last_acc), 64'(1));
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, 64'({out_valid_m, out_valid_l}), 64'(0));
        chk({tag, "_data"},  64'({out_data_m, out_data_l}),   64'(0));
        chk({tag, "_meta"},  64'({out_last_m, out_last_l, out_count_m, out_count_l}), 64'(0));
        chk({tag, "_fill"},  64'({fill_m, fill_l}),           64'(0));
        chk({tag, "_rdy"},   64'({in_ready_m, in_ready_l}),   64'(2'b11));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_zero("rst_async");
        q.delete();
        part.delete();
        in_valid = 1'b1;
        in_data  = 8'h5A;
        repeat (2) @(negedge clk);
        check_zero("rst_hold");
        in_valid = 1'b0;
        rst_n    = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;

        // Full word, back to back, consumer ready.
        out_ready = 1'b1;
        send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0);
        #1;
        chk("t1_valid", 64'(out_valid_m), 64'(1));
        chk("t1_data_m", 64'(out_data_m), 64'(32'h00112233));
        chk("t1_data_l", 64'(out_data_l), 64'(32'h00332211));
        chk("t1_cnt", 64'(out_count_m), 64'(3));
        chk("t1_last", 64'(out_last_m), 64'(0));

        send(8'hAA, 1'b0); send(8'hBB, 1'b0); send(8'hCC, 1'b0);
        #1;
        chk("t2_data_l", 64'(out_data_l), 64'(32'h00CCBBAA));
        chk("t2_data_m", 64'(out_data_m), 64'(32'h00AABBCC));

        // Partial word closed by in_last, then a fresh word.
        send(8'h44, 1'b0); send(8'h55, 1'b1);
        #1;
        chk("t3_data_m", 64'(out_data_m), 64'(32'h00445500));
        chk("t3_data_l", 64'(out_data_l), 64'(32'h00005544));
        chk("t3_cnt", 64'(out_count_m), 64'(2));
        chk("t3_last", 64'(out_last_m), 64'(1));
        send(8'h66, 1'b0); send(8'h77, 1'b0); send(8'h88, 1'b0);
        #1;
        chk("t3b_data_m", 64'(out_data_m), 64'(32'h00667788));
        chk("t3b_last", 64'(out_last_m), 64'(0));
        tick();

        // Backpressure: fill the FIFO, then drain.
        out_ready = 1'b0;
        for (int i = 0; i < 12; i++) send(8'(i + 1), 1'b0);
        #1;
        chk("t4_fill", 64'(fill_m), 64'(DEPTH));
        chk("t4_rdy", 64'(in_ready_m), 64'(0));
        in_valid = 1'b1; in_data = 8'hEE;
        tick(); tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        #1;
        chk("t4_rdy_back", 64'(in_ready_m), 64'(1));
        chk("t4_fill3", 64'(fill_m), 64'(3));
        repeat (4) tick();

        // Clear with queued words and a partial element.
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) send(8'($urandom), 1'b0);
        #1;
        chk("t5_fill2", 64'(fill_m), 64'(2));
        in_valid = 1'b1; in_data = 8'h99; clear = 1'b1;
        tick();
        clear = 1'b0; in_valid = 1'b0;
        #1;
        chk("t5_valid", 64'(out_valid_m), 64'(0));
        chk("t5_fill", 64'(fill_m), 64'(0));
        send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0);
        #1;
        chk("t5_data_m", 64'(out_data_m), 64'(32'h00010203));
        out_ready = 1'b1;
        tick();

        // Reset mid-operation.
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) send(8'($urandom), 1'b0);
        do_reset();
        send(8'hA1, 1'b0); send(8'hB2, 1'b0); send(8'hC3, 1'b0);
        #1;
        chk("t6_data_m", 64'(out_data_m), 64'(32'h00A1B2C3));
        chk("t6_data_l", 64'(out_data_l), 64'(32'h00C3B2A1));
        chk("t6_fill", 64'(fill_m), 64'(1));

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom % 4) != 0;
            in_data   = 8'($urandom);
            in_last   = ($urandom % 5) == 0;
            out_ready = ($urandom % 3) != 0;
            clear     = ($urandom % 60) == 0;
            tick();
        end
        in_valid = 1'b0; clear = 1'b0; out_ready = 1'b1;
        repeat (6) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
